bit_population_frame_stats: RTL and testbench
=============================================

// Module: bit_population_frame_stats
// PURPOSE
//  Downstream stage of the bit population counter. Consumes the per-word popcount stream
//  (count + valid, no backpressure) and groups it into frames of FRAME_LEN words.
//  For each frame it reports the sum, maximum and minimum popcount, plus the word count.
//  Results go through a 2-entry buffer with a valid/ready handshake.
// PARAMETERS
//  WIDTH      20  data width of the upstream popcount stage; input counts lie in 0..WIDTH
//  FRAME_LEN  16  words per full frame; >=2
//  CNT_W      (derived) $clog2(WIDTH)+1, width of input count, max_o and min_o
//  SUM_W      (derived) $clog2(WIDTH*FRAME_LEN+1), width of sum_o; the sum can never wrap
//  WRD_W      (derived) $clog2(FRAME_LEN+1), width of words_o
// PORTS
//  clk_i          in   1      clock
//  arst_n_i       in   1      reset; asynchronous, active-low
//  data_i         in   CNT_W  popcount of one word
//  data_val_i     in   1      data_i valid; always accepted
//  flush_i        in   1      close the current partial frame
//  frame_ready_i  in   1      consumer ready
//  clr_ovf_i      in   1      clear overflow_o
//  frame_val_o    out  1      result at buffer head is valid
//  sum_o          out  SUM_W  sum of counts in the frame
//  max_o          out  CNT_W  largest count in the frame
//  min_o          out  CNT_W  smallest count in the frame
//  words_o        out  WRD_W  words in the frame, 1..FRAME_LEN
//  overflow_o     out  1      sticky flag: a frame result was dropped
// BEHAVIOUR
//  - Reset (arst_n_i=0, async): all outputs 0, accumulator cleared, buffer empty, FSM IDLE.
//  - FSM IDLE: word_cnt=0. data_val_i loads sum=max=min=data_i and word_cnt=1 -> ACCUM.
//  - FSM ACCUM: on data_val_i: sum+=data_i, max/min updated, word_cnt++.
//  - Frame close: occurs when the accepted word makes word_cnt=FRAME_LEN, or when flush_i=1 with
//    word_cnt>0 after including any same-cycle word. The result {sum,max,min,words} includes
//    that cycle's word. The accumulator returns to IDLE on the same edge.
//  - Back-to-back frames: a word arriving the cycle after a close starts the new frame with no gap.
//  - flush_i in IDLE with data_val_i=0: no effect. flush_i with data_val_i in IDLE: 1-word frame.
//  - Latency: the result is visible on the outputs one cycle after the edge that accepts the
//    closing word, provided the buffer was not full.
//  - Buffer: 2-entry FIFO. frame_val_o = not empty. Outputs show the head; otherwise they hold
//    their last value. A pop occurs on frame_val_o & frame_ready_i. Order is preserved.
//  - A push and a pop in the same cycle are both performed, including when the buffer is full.
//  - Push while full and no pop: the new result is dropped, the buffer is unchanged and
//    overflow_o<=1.
//  - overflow_o clears only on clr_ovf_i. A set and a clear in the same cycle leave it set.
//  - Input data_i>WIDTH is illegal; the bench asserts this; RTL behaviour is undefined.
//  - Reset mid-frame discards the partial frame and all buffered results.
// STRUCTURE
//  - Package bit_population_pkg: functions cnt_width(w) and sum_width(w,n); FSM state enum
//    {IDLE,ACCUM}.
//  - Sub-module bit_population_res_fifo: 2-entry FIFO, parameter DATA_W, async active-low reset.
//  - Top level: accumulator, FSM and overflow flag; the result is packed as one DATA_W vector.
// TESTING (WIDTH=20, FRAME_LEN=4 unless noted)
//  1. Counts 3,7,0,20 on consecutive cycles -> next cycle: frame_val_o=1, sum=30, max=20, min=0,
//     words=4.
//  2. Counts 5,5 with flush_i on the 2nd word's cycle -> sum=10, max=5, min=5, words=2.
//     Lone flush_i in IDLE -> no frame.
//  3. frame_ready_i=0, three full frames -> first two held in order, third dropped,
//     overflow_o=1. Then ready=1 -> two pops, then frame_val_o=0.
//  4. Buffer full, frame closes in the same cycle as a pop -> no drop, overflow_o stays 0.
//     Clear and set in the same cycle -> overflow_o=1.
//  5. Counts 1,2,3,4 with random idle gaps in data_val_i -> sum=10, max=4, min=1, words=4.
//     Next frame follows with no gap.
//  6. arst_n_i low after 2 words -> all outputs 0 immediately. Then 4 words of 20 ->
//     sum=80, words=4, no leftover data.

Source files
------------

// File: rtl/bit_population_pkg.sv
// Package for the bit population frame statistics stage.
// Holds the width helper functions and the accumulator FSM state type.
package bit_population_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    // Width of a popcount of a w-bit word (values 0..w).
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    // Width of a sum of n popcounts of w-bit words; large enough that it never wraps.
    function automatic int unsigned sum_width(input int unsigned w, input int unsigned n);
        return $clog2(w * n + 1);
    endfunction

endpackage

// File: rtl/bit_population_res_fifo.sv
// Two-entry result FIFO with valid/ready read side and no write backpressure.
// Ports:
//   clk_i, arst_n_i   clock, asynchronous active-low reset
//   push_i, push_data_i  write request and data (never stalled)
//   pop_i             read request; ignored while empty
//   val_o             FIFO not empty
//   data_o            head entry; holds the last head value while empty
//   drop_o            push rejected because full with no same-cycle pop
module bit_population_res_fifo #(
    parameter int unsigned DATA_W = 8
)(
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              val_o,
    output logic [DATA_W-1:0] data_o,
    output logic              drop_o
);

    logic [DATA_W-1:0] mem_q [0:1];
    logic [DATA_W-1:0] last_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              empty;
    logic              full;
    logic              do_pop;
    logic              do_push;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign do_pop  = pop_i & ~empty;
    // A pop frees the head slot on the same edge, so a full FIFO can still take a push.
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & full & ~do_pop;

    assign val_o  = ~empty;
    assign data_o = empty ? last_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Track the current head so the outputs hold it once the FIFO drains.
            if (!empty) begin
                last_q <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bit_population_frame_stats.sv
// Frame statistics stage for the bit population counter.
// Groups the per-word popcount stream into frames of FRAME_LEN words (or shorter
// frames closed by flush_i) and reports sum, max, min and word count per frame
// through a 2-entry valid/ready buffer.
// Ports:
//   clk_i, arst_n_i  clock, asynchronous active-low reset
//   data_i           popcount of one word (0..WIDTH), data_val_i qualifies it
//   flush_i          close the current partial frame
//   frame_ready_i    consumer ready; pop on frame_val_o & frame_ready_i
//   clr_ovf_i        clear overflow_o
//   frame_val_o      buffer head valid
//   sum_o/max_o/min_o/words_o  head frame result (held while empty)
//   overflow_o       sticky: a frame result was dropped on a full buffer
module bit_population_frame_stats
    import bit_population_pkg::*;
#(
    parameter  int unsigned WIDTH     = 20,
    parameter  int unsigned FRAME_LEN = 16,
    localparam int unsigned CNT_W     = cnt_width(WIDTH),
    localparam int unsigned SUM_W     = sum_width(WIDTH, FRAME_LEN),
    localparam int unsigned WRD_W     = $clog2(FRAME_LEN + 1)
)(
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [CNT_W-1:0] data_i,
    input  logic             data_val_i,
    input  logic             flush_i,
    input  logic             frame_ready_i,
    input  logic             clr_ovf_i,
    output logic             frame_val_o,
    output logic [SUM_W-1:0] sum_o,
    output logic [CNT_W-1:0] max_o,
    output logic [CNT_W-1:0] min_o,
    output logic [WRD_W-1:0] words_o,
    output logic             overflow_o
);

    localparam int unsigned DATA_W = SUM_W + 2 * CNT_W + WRD_W;

    acc_state_t        state_q, state_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  max_q, max_d;
    logic [CNT_W-1:0]  min_q, min_d;
    logic [WRD_W-1:0]  cnt_q, cnt_d;
    logic              close;
    logic [DATA_W-1:0] res_push;
    logic [DATA_W-1:0] res_head;
    logic              res_drop;

    // *_d are the accumulator values including this cycle's word; a closing
    // frame reports them directly so the closing word is part of the result.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        max_d   = max_q;
        min_d   = min_q;
        cnt_d   = cnt_q;
        close   = 1'b0;

        if (data_val_i) begin
            if (state_q == IDLE) begin
                sum_d = SUM_W'(data_i);
                max_d = data_i;
                min_d = data_i;
                cnt_d = WRD_W'(1);
            end else begin
                sum_d = sum_q + SUM_W'(data_i);
                if (data_i > max_q) max_d = data_i;
                if (data_i < min_q) min_d = data_i;
                cnt_d = cnt_q + WRD_W'(1);
            end
            state_d = ACCUM;
        end

        if ((data_val_i && (cnt_d == WRD_W'(FRAME_LEN))) || (flush_i && (cnt_d != '0))) begin
            close   = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            sum_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            min_q   <= min_d;
            // word count doubles as the "frame open" indicator, so zero it on close
            cnt_q   <= close ? '0 : cnt_d;
        end
    end

    assign res_push = {sum_d, max_d, min_d, cnt_d};

    bit_population_res_fifo #(
        .DATA_W (DATA_W)
    ) u_res_fifo (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .push_i      (close),
        .push_data_i (res_push),
        .pop_i       (frame_ready_i),
        .val_o       (frame_val_o),
        .data_o      (res_head),
        .drop_o      (res_drop)
    );

    assign {sum_o, max_o, min_o, words_o} = res_head;

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            overflow_o <= 1'b0;
        end else if (res_drop) begin
            overflow_o <= 1'b1;
        end else if (clr_ovf_i) begin
            overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_population_frame_stats.sv
module tb_bit_population_frame_stats;

    localparam int unsigned WIDTH     = 20;
    localparam int unsigned FRAME_LEN = 4;

    logic       clk;
    logic       arst_n;
    logic [5:0] data;
    logic       data_val;
    logic       flush;
    logic       frame_ready;
    logic       clr_ovf;
    logic       frame_val;
    logic [6:0] sum;
    logic [5:0] max_v;
    logic [5:0] min_v;
    logic [2:0] words;
    logic       overflow;

    bit_population_frame_stats #(
        .WIDTH     (WIDTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk_i         (clk),
        .arst_n_i      (arst_n),
        .data_i        (data),
        .data_val_i    (data_val),
        .flush_i       (flush),
        .frame_ready_i (frame_ready),
        .clr_ovf_i     (clr_ovf),
        .frame_val_o   (frame_val),
        .sum_o         (sum),
        .max_o         (max_v),
        .min_o         (min_v),
        .words_o       (words),
        .overflow_o    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (arst_n && data_val) begin
            assert (data <= 6'(WIDTH)) else $error("illegal input count %0d", data);
        end
    end

    typedef struct {
        logic [5:0] d;
        logic       v, f, r, c;
        logic       e_val;
        int         e_sum, e_max, e_min, e_words;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input int rep, input int d, input bit v, input bit f, input bit r,
                       input bit c, input bit ev, input int es, input int emx, input int emn,
                       input int ew, input bit eo);
        vec_t t;
        t.d = 6'(d); t.v = v; t.f = f; t.r = r; t.c = c;
        t.e_val = ev; t.e_sum = es; t.e_max = emx; t.e_min = emn; t.e_words = ew; t.e_ovf = eo;
        for (int i = 0; i < rep; i++) vecs.push_back(t);
    endtask

    task automatic check(input string nm, input bit ev, input int es, input int emx,
                         input int emn, input int ew, input bit eo);
        n_vec++;
        if (frame_val !== ev || int'(sum) != es || int'(max_v) != emx || int'(min_v) != emn ||
            int'(words) != ew || overflow !== eo) begin
            n_err++;
            $display("FAIL %s: got val=%0b sum=%0d max=%0d min=%0d words=%0d ovf=%0b, want val=%0b sum=%0d max=%0d min=%0d words=%0d ovf=%0b",
                     nm, frame_val, sum, max_v, min_v, words, overflow, ev, es, emx, emn, ew, eo);
        end
    endtask

    task automatic drive(input int d, input bit v, input bit f, input bit r, input bit c);
        data = 6'(d); data_val = v; flush = f; frame_ready = r; clr_ovf = c;
    endtask

    initial begin
        arst_n = 1'b0;
        drive(0, 0, 0, 0, 0);

        //  rep  d v f r c   val sum max min w ovf
        // full frame 3,7,0,20
        add(1,  3, 1,0,0,0,  0,  0,  0, 0, 0, 0);
        add(1,  7, 1,0,0,0,  0,  0,  0, 0, 0, 0);
        add(1,  0, 1,0,0,0,  0,  0,  0, 0, 0, 0);
        add(1, 20, 1,0,0,0,  1, 30, 20, 0, 4, 0);
        add(1,  0, 0,0,1,0,  0, 30, 20, 0, 4, 0);
        // flushed 2-word frame, lone flushes, 1-word flushed frame
        add(1,  5, 1,0,0,0,  0, 30, 20, 0, 4, 0);
        add(1,  5, 1,1,0,0,  1, 10,  5, 5, 2, 0);
        add(1,  0, 0,0,1,0,  0, 10,  5, 5, 2, 0);
        add(2,  0, 0,1,0,0,  0, 10,  5, 5, 2, 0);
        add(1,  0, 0,0,0,0,  0, 10,  5, 5, 2, 0);
        add(1,  9, 1,1,0,0,  1,  9,  9, 9, 1, 0);
        add(1,  0, 0,0,1,0,  0,  9,  9, 9, 1, 0);
        // 1,2,3,4 with idle gaps, then back-to-back frame of 6s
        add(1,  1, 1,0,0,0,  0,  9,  9, 9, 1, 0);
        add(1,  0, 0,0,0,0,  0,  9,  9, 9, 1, 0);
        add(1,  2, 1,0,0,0,  0,  9,  9, 9, 1, 0);
        add(2,  0, 0,0,0,0,  0,  9,  9, 9, 1, 0);
        add(1,  3, 1,0,0,0,  0,  9,  9, 9, 1, 0);
        add(1,  0, 0,0,0,0,  0,  9,  9, 9, 1, 0);
        add(1,  4, 1,0,0,0,  1, 10,  4, 1, 4, 0);
        add(1,  6, 1,0,1,0,  0, 10,  4, 1, 4, 0);
        add(2,  6, 1,0,0,0,  0, 10,  4, 1, 4, 0);
        add(1,  6, 1,0,0,0,  1, 24,  6, 6, 4, 0);
        add(1,  0, 0,0,1,0,  0, 24,  6, 6, 4, 0);
        // three frames into a stalled buffer: third dropped
        add(3,  1, 1,0,0,0,  0, 24,  6, 6, 4, 0);
        add(1,  1, 1,0,0,0,  1,  4,  1, 1, 4, 0);
        add(4,  2, 1,0,0,0,  1,  4,  1, 1, 4, 0);
        add(3,  3, 1,0,0,0,  1,  4,  1, 1, 4, 0);
        add(1,  3, 1,0,0,0,  1,  4,  1, 1, 4, 1);
        add(1,  0, 0,0,1,0,  1,  8,  2, 2, 4, 1);
        add(2,  0, 0,0,1,0,  0,  8,  2, 2, 4, 1);
        // clear, then close on a full buffer while popping: no drop
        add(1,  0, 0,0,0,1,  0,  8,  2, 2, 4, 0);
        add(3,  1, 1,0,0,0,  0,  8,  2, 2, 4, 0);
        add(1,  1, 1,0,0,0,  1,  4,  1, 1, 4, 0);
        add(4,  2, 1,0,0,0,  1,  4,  1, 1, 4, 0);
        add(3,  5, 1,0,0,0,  1,  4,  1, 1, 4, 0);
        add(1,  5, 1,0,1,0,  1,  8,  2, 2, 4, 0);
        add(1,  0, 0,0,0,0,  1,  8,  2, 2, 4, 0);
        // drop and clear in the same cycle: set wins
        add(3,  1, 1,0,0,0,  1,  8,  2, 2, 4, 0);
        add(1,  1, 1,0,0,1,  1,  8,  2, 2, 4, 1);
        add(1,  0, 0,0,1,0,  1, 20,  5, 5, 4, 1);
        add(1,  0, 0,0,1,0,  0, 20,  5, 5, 4, 1);
        add(1,  0, 0,0,0,0,  0, 20,  5, 5, 4, 1);

        repeat (2) @(posedge clk);
        #1 check("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk) arst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(int'(vecs[i].d), vecs[i].v, vecs[i].f, vecs[i].r, vecs[i].c);
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), vecs[i].e_val, vecs[i].e_sum, vecs[i].e_max,
                     vecs[i].e_min, vecs[i].e_words, vecs[i].e_ovf);
        end

        // reset mid-frame: asynchronous clear, partial frame discarded
        drive(7, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 drive(0, 0, 0, 0, 0);
        #2 arst_n = 1'b0;
        #1 check("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk) arst_n = 1'b1;
        @(posedge clk);
        #1 drive(20, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 check("post_reset_partial", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 check("post_reset_frame", 1, 80, 20, 20, 4, 0);
        drive(0, 0, 0, 1, 0);
        @(posedge clk);
        #1 check("post_reset_pop", 0, 80, 20, 20, 4, 0);
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1 check("no_leftover", 0, 80, 20, 20, 4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
